// File: rtl/peripheral_noc_packetizer_if.sv
// Request, payload and NoC-injection signals for one packetizer slot.
// slave is the packetizer's view; master is the view of whatever drives it.
interface peripheral_noc_packetizer_if #(
  parameter int FLIT_WIDTH = 34,
  parameter int DEST_WIDTH = 4,
  parameter int LEN_WIDTH  = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic [DEST_WIDTH-1:0] req_dest;
  logic [2:0]            req_class;
  logic [LEN_WIDTH-1:0]  req_len;

  logic [FLIT_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  data_ready;

  logic [FLIT_WIDTH-1:0] out_flit;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  logic                  err_len;
  logic [15:0]           pkt_count;

  modport slave (
    input  req_valid, req_dest, req_class, req_len,
    input  data_in, data_valid,
    input  out_ready,
    output req_ready, data_ready,
    output out_flit, out_last, out_valid,
    output err_len, pkt_count
  );

  modport master (
    output req_valid, req_dest, req_class, req_len,
    output data_in, data_valid,
    output out_ready,
    input  req_ready, data_ready,
    input  out_flit, out_last, out_valid,
    input  err_len, pkt_count
  );
endinterface

// File: rtl/peripheral_noc_packetizer.sv
// NoC injection packetizer: header flit from a request, then the payload words,
// through a single registered output stage that sustains one flit per cycle.
module peripheral_noc_packetizer #(
  parameter int FLIT_WIDTH  = 34,
  parameter int DEST_WIDTH  = 4,
  parameter int NODE_ID     = 0,
  parameter int MAX_PAYLOAD = 8,
  parameter int LEN_WIDTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  peripheral_noc_packetizer_if.slave    bus
);

  localparam logic [LEN_WIDTH-1:0]  MaxLen   = LEN_WIDTH'(MAX_PAYLOAD);
  localparam logic [DEST_WIDTH-1:0] NodeAddr = DEST_WIDTH'(NODE_ID);
  localparam int                    ClassLsb = FLIT_WIDTH - DEST_WIDTH - 3;
  localparam int                    NodeLsb  = ClassLsb - DEST_WIDTH;

  typedef enum logic {
    S_IDLE,
    S_PAYLOAD
  } state_e;

  state_e                state_q, state_d;
  logic [FLIT_WIDTH-1:0] flit_q, flit_d;
  logic                  last_q, last_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [15:0]           pkt_q, pkt_d;
  logic [LEN_WIDTH-1:0]  count_q, count_d;

  logic                  load_ok;
  logic                  req_fire;
  logic                  data_fire;
  logic                  len_over;
  logic                  final_word;
  logic [LEN_WIDTH-1:0]  len_c;
  logic [FLIT_WIDTH-1:0] header;

  // The output register may take a new flit when empty or emptying this cycle.
  assign load_ok    = !valid_q || bus.out_ready;
  assign req_fire   = bus.req_valid && bus.req_ready;
  assign data_fire  = bus.data_valid && bus.data_ready;
  assign len_over   = bus.req_len > MaxLen;
  assign len_c      = len_over ? MaxLen : bus.req_len;
  assign final_word = count_q == LEN_WIDTH'(1);

  always_comb begin
    header                               = '0;
    header[FLIT_WIDTH-1 -: DEST_WIDTH]   = bus.req_dest;
    header[ClassLsb +: 3]                = bus.req_class;
    header[NodeLsb +: DEST_WIDTH]        = NodeAddr;
    header[LEN_WIDTH-1:0]                = len_c;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_fire && (len_c != '0)) begin
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (data_fire && final_word) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Handshake outputs
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.data_ready = 1'b0;
    case (state_q)
      S_IDLE:    bus.req_ready  = load_ok;
      S_PAYLOAD: bus.data_ready = load_ok;
    endcase
  end

  always_comb begin
    flit_d  = flit_q;
    last_d  = last_q;
    valid_d = valid_q;
    count_d = count_q;
    err_d   = 1'b0;
    pkt_d   = pkt_q;

    if (valid_q && bus.out_ready && last_q) begin
      pkt_d = pkt_q + 16'd1;
    end

    if (load_ok) begin
      valid_d = 1'b0;
    end

    if (req_fire) begin
      flit_d  = header;
      last_d  = (len_c == '0);
      valid_d = 1'b1;
      count_d = len_c;
      err_d   = len_over;
    end else if (data_fire) begin
      flit_d  = bus.data_in;
      last_d  = final_word;
      valid_d = 1'b1;
      count_d = count_q - LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flit_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
      pkt_q   <= '0;
    end else begin
      flit_q  <= flit_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      count_q <= count_d;
      err_q   <= err_d;
      pkt_q   <= pkt_d;
    end
  end

  assign bus.out_flit  = flit_q;
  assign bus.out_last  = last_q;
  assign bus.out_valid = valid_q;
  assign bus.err_len   = err_q;
  assign bus.pkt_count = pkt_q;

endmodule

// File: tb/tb_peripheral_noc_packetizer.sv
// Bench for peripheral_noc_packetizer: table of packets with literal headers,
// hand-written corner sequences, and randomized traffic against a flit-queue model.
`timescale 1ns/1ps
module tb_peripheral_noc_packetizer;

  localparam int FW   = 34;
  localparam int DW   = 4;
  localparam int LW   = 4;
  localparam int MAXP = 8;
  localparam int NODE = 3;
  localparam int TMO  = 300;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  peripheral_noc_packetizer_if #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  peripheral_noc_packetizer #(
    .FLIT_WIDTH (FW),
    .DEST_WIDTH (DW),
    .NODE_ID    (NODE),
    .MAX_PAYLOAD(MAXP),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [FW-1:0] flit;
    logic          last;
  } flit_t;

  typedef struct {
    logic [DW-1:0] dest;
    logic [2:0]    cls;
    logic [LW-1:0] len;
    int            n;
    logic [FW-1:0] hdr;
    logic [FW-1:0] w0;
    logic [FW-1:0] w1;
    int            err;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  flit_t       expq[$];
  int          rdy_mode = 0;
  int          pat_idx = 0;
  int          cyc = 0;
  logic [15:0] model_pkts = '0;
  int          err_seen = 0;
  int          err_exp = 0;
  int          dr_cnt = 0;
  int          acc_cnt = 0;
  int          first_acc = -1;
  int          last_acc = -1;
  logic        prev_stall = 1'b0;
  logic        prev_err = 1'b0;
  logic [FW-1:0] prev_flit = '0;
  logic        prev_last = 1'b0;
  logic [FW-1:0] fixed_w[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] hdr_model(input int dest, input int cls, input int len);
    longint v;
    int     n;
    n = (len > MAXP) ? MAXP : len;
    v = longint'(dest) * (longint'(1) << 30) + longint'(cls) * (longint'(1) << 27)
      + longint'(NODE) * (longint'(1) << 23) + longint'(n);
    return FW'(v);
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: begin
        bus.out_ready = (pat_idx % 3 == 0);
        pat_idx++;
      end
    endcase
  end

  always @(negedge clk) begin
    flit_t e;
    if (!rst) begin
      prev_stall = 1'b0;
      prev_err   = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        check("stall_flit", 64'(bus.out_flit), 64'(prev_flit));
        check("stall_last", 64'(bus.out_last), 64'(prev_last));
      end
      check("ready_excl", 64'(bus.req_ready & bus.data_ready), 64'd0);
      if (bus.data_ready) dr_cnt++;
      if (bus.err_len) begin
        err_seen++;
        check("err_pulse", 64'(prev_err), 64'd0);
      end
      prev_err = bus.err_len;
      if (bus.out_valid && bus.out_ready) begin
        acc_cnt++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_flit: got %h last=%0d expected no flit", bus.out_flit, bus.out_last);
        end else begin
          e = expq.pop_front();
          check("flit", 64'(bus.out_flit), 64'(e.flit));
          check("last", 64'(bus.out_last), 64'(e.last));
          if (e.last) begin
            check("pkt_count_live", 64'(bus.pkt_count), 64'(model_pkts));
            model_pkts = model_pkts + 16'd1;
          end
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_flit  = bus.out_flit;
      prev_last  = bus.out_last;
    end
  end

  task automatic wait_hs(input bit is_data, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < TMO; t++) begin
      @(negedge clk);
      if (is_data ? (bus.data_valid && bus.data_ready) : (bus.req_valid && bus.req_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: no handshake within %0d cycles", is_data ? "data" : "req", TMO);
    end
  endtask

  task automatic send_pkt(input logic [DW-1:0] dest, input logic [2:0] cls, input logic [LW-1:0] len,
                          input logic [FW-1:0] hdr, input int gap, input bit pre);
    int            n;
    bit            ok;
    logic [63:0]   r;
    logic [FW-1:0] w[$];
    flit_t         f;
    n = (int'(len) > MAXP) ? MAXP : int'(len);
    for (int i = 0; i < n; i++) begin
      if (fixed_w.size() != 0) begin
        w.push_back(fixed_w.pop_front());
      end else begin
        r = {$urandom(), $urandom()};
        w.push_back(r[FW-1:0]);
      end
    end
    fixed_w.delete();
    f.flit = hdr;
    f.last = (n == 0);
    expq.push_back(f);
    for (int i = 0; i < n; i++) begin
      f.flit = w[i];
      f.last = (i == n - 1);
      expq.push_back(f);
    end
    if (int'(len) > MAXP) err_exp++;

    if (pre && n > 0) begin
      bus.data_valid = 1'b1;
      bus.data_in    = w[0];
    end
    bus.req_valid = 1'b1;
    bus.req_dest  = dest;
    bus.req_class = cls;
    bus.req_len   = len;
    wait_hs(1'b0, ok);
    bus.req_valid = 1'b0;
    if (!ok) begin
      bus.data_valid = 1'b0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (!(pre && i == 0)) begin
        repeat ($urandom_range(0, gap)) begin
          bus.data_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      bus.data_valid = 1'b1;
      bus.data_in    = w[i];
      wait_hs(1'b1, ok);
      if (!ok) break;
    end
    bus.data_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (expq.size() != 0 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (expq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d flits outstanding, expected 0", expq.size());
      expq.delete();
    end
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        tv[5];
    int          d0;
    logic [15:0] p0;
    int          a0;
    bit          ok;
    int          rlen;
    flit_t       f;

    bus.req_valid  = 1'b0;
    bus.req_dest   = '0;
    bus.req_class  = '0;
    bus.req_len    = '0;
    bus.data_in    = '0;
    bus.data_valid = 1'b0;

    tv[0] = '{dest: 4'd5,  cls: 3'd2, len: 4'd2,  n: 2, hdr: 34'h1_5180_0002, w0: 34'h0_0000_00AA, w1: 34'h0_0000_00BB, err: 0};
    tv[1] = '{dest: 4'd15, cls: 3'd0, len: 4'd0,  n: 0, hdr: 34'h3_C180_0000, w0: '0, w1: '0, err: 0};
    tv[2] = '{dest: 4'd5,  cls: 3'd2, len: 4'd11, n: 8, hdr: 34'h1_5180_0008, w0: 34'h0_1234_5678, w1: 34'h3_FFFF_FFFF, err: 1};
    tv[3] = '{dest: 4'd0,  cls: 3'd7, len: 4'd8,  n: 8, hdr: 34'h0_3980_0008, w0: 34'h2_AAAA_5555, w1: 34'h1_0000_0001, err: 0};
    tv[4] = '{dest: 4'd9,  cls: 3'd1, len: 4'd15, n: 8, hdr: 34'h2_4980_0008, w0: 34'h0_0000_0000, w1: 34'h3_0000_0000, err: 1};

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_out_flit", 64'(bus.out_flit), 64'd0);
    check("rst_err_len", 64'(bus.err_len), 64'd0);
    check("rst_pkt_count", 64'(bus.pkt_count), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_data_ready", 64'(bus.data_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Table: literal headers, out_ready held high, data presented with no gaps
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) begin
      d0 = dr_cnt;
      fixed_w.push_back(tv[i].w0);
      fixed_w.push_back(tv[i].w1);
      send_pkt(tv[i].dest, tv[i].cls, tv[i].len, tv[i].hdr, 0, 1'b0);
      drain();
      check("tbl_pkt_count", 64'(bus.pkt_count), 64'(i + 1));
      check("tbl_dready_cycles", 64'(dr_cnt - d0), 64'(tv[i].n));
      check("tbl_err_count", 64'(err_seen), 64'(err_exp));
    end
    check("tbl_err_total", 64'(err_seen), 64'd2);

    // Backpressure: out_ready pattern 1,0,0 repeating
    rdy_mode = 2;
    p0 = model_pkts;
    for (int i = 0; i < 3; i++) begin
      send_pkt(4'(i + 1), 3'(i), 4'd3, hdr_model(i + 1, i, 3), 2, 1'b0);
    end
    drain();
    check("bp_pkt_count", 64'(bus.pkt_count), 64'(p0 + 16'd3));

    // Reset in the middle of a len=4 packet, then a len=1 packet
    rdy_mode = 0;
    @(posedge clk);
    #1;
    f.flit = hdr_model(6, 1, 4);
    f.last = 1'b0;
    expq.push_back(f);
    bus.req_valid = 1'b1;
    bus.req_dest  = 4'd6;
    bus.req_class = 3'd1;
    bus.req_len   = 4'd4;
    wait_hs(1'b0, ok);
    bus.req_valid  = 1'b0;
    bus.data_valid = 1'b1;
    bus.data_in    = 34'h0_DEAD_BEEF;
    wait_hs(1'b1, ok);
    bus.data_valid = 1'b0;
    check("mid_hdr_sent", 64'(expq.size()), 64'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_pkt_count", 64'(bus.pkt_count), 64'd0);
    check("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("mid_rst_data_ready", 64'(bus.data_ready), 64'd0);
    expq.delete();
    model_pkts = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_no_residue", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    fixed_w.push_back(34'h2_0F0F_0F0F);
    send_pkt(4'd2, 3'd4, 4'd1, 34'h0_A180_0001, 0, 1'b0);
    drain();
    check("post_rst_pkt_count", 64'(bus.pkt_count), 64'd1);

    // Throughput: three len=2 packets, data already valid before each request
    rdy_mode = 0;
    p0 = model_pkts;
    a0 = acc_cnt;
    first_acc = -1;
    for (int i = 0; i < 3; i++) begin
      send_pkt(4'd7, 3'd3, 4'd2, hdr_model(7, 3, 2), 0, 1'b1);
    end
    drain();
    check("tp_flits", 64'(acc_cnt - a0), 64'd9);
    check("tp_within_11", 64'((last_acc - first_acc + 1) <= 11), 64'd1);
    check("tp_pkt_count", 64'(bus.pkt_count), 64'(p0 + 16'd3));

    // Randomized traffic against the flit-queue model
    rdy_mode = 1;
    p0 = model_pkts;
    for (int i = 0; i < 40; i++) begin
      int rd;
      int rc;
      rd   = $urandom_range(0, 15);
      rc   = $urandom_range(0, 7);
      rlen = $urandom_range(0, 15);
      send_pkt(4'(rd), 3'(rc), 4'(rlen), hdr_model(rd, rc, rlen), 2, 1'($urandom_range(0, 1)));
    end
    drain();
    check("rand_pkt_count", 64'(bus.pkt_count), 64'(p0 + 16'd40));
    check("rand_err_count", 64'(err_seen), 64'(err_exp));
    check("final_idle", 64'(bus.out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
